// File: rtl/alu_multiciclo_if.sv
// Request/response bundle for alu_multiciclo: operands and start go in; result, flags and handshake come out.
// `ALU_HILO_EN adds the hi word (upper product / remainder).
interface alu_multiciclo_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) ();
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div_by_zero;
`ifdef ALU_HILO_EN
    logic [WIDTH-1:0] hi;

    modport master (output start, op, a, b, shamt,
                    input  result, zero, busy, done, div_by_zero, hi);
    modport slave  (input  start, op, a, b, shamt,
                    output result, zero, busy, done, div_by_zero, hi);
`else
    modport master (output start, op, a, b, shamt,
                    input  result, zero, busy, done, div_by_zero);
    modport slave  (input  start, op, a, b, shamt,
                    output result, zero, busy, done, div_by_zero);
`endif
endinterface

// File: rtl/alu_multiciclo.sv
// Execution-stage ALU: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIV.
// Optional `ALU_HILO_EN exposes the upper product / remainder on bus.hi.
module alu_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_multiciclo_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5, OP_NOR = 4'd6, OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SLT = 4'd9, OP_XOR = 4'd10;

    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_nxt;

    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;
    logic             is_div, b_zero;
    logic [WIDTH-1:0] nxt_hi, nxt_lo, alu_res;
    logic [WIDTH:0]   sum, shifted, diff;
    logic             iter_op, accept, last;

    logic [WIDTH-1:0] result_q;
    logic             zero_q, done_q, dbz_q;
`ifdef ALU_HILO_EN
    logic [WIDTH-1:0] hi_q;
    assign bus.hi = hi_q;
`endif

    assign iter_op = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign accept  = (state == IDLE) && bus.start;
    assign last    = (cnt == (SHW+1)'(WIDTH-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && iter_op) state_nxt = CALC;
            CALC: if (last)              state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == CALC);
    end

    always_comb begin
        alu_res = bus.a + bus.b;
        case (bus.op)
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLL:  alu_res = bus.b << bus.shamt;
            OP_SRL:  alu_res = bus.b >> bus.shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_XOR:  alu_res = bus.a ^ bus.b;
            default: alu_res = bus.a + bus.b;
        endcase
    end

    // One iteration. MUL: {acc_hi,acc_lo} is the product/multiplier pair shifted right.
    // DIV: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    // Remainder stays below the divisor, so diff[WIDTH] is a valid borrow bit.
    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        diff    = shifted - {1'b0, opd};
        if (is_div) begin
            nxt_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opd      <= '0;
            is_div   <= 1'b0;
            b_zero   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
`ifdef ALU_HILO_EN
            hi_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (iter_op) begin
                        acc_hi <= '0;
                        acc_lo <= (bus.op == OP_MUL) ? bus.b : bus.a;
                        opd    <= (bus.op == OP_MUL) ? bus.a : bus.b;
                        is_div <= (bus.op == OP_DIV);
                        b_zero <= (bus.b == '0);
                        cnt    <= '0;
                    end else begin
                        result_q <= alu_res;
                        zero_q   <= (alu_res == '0);
                        dbz_q    <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        result_q <= nxt_lo;
                        zero_q   <= (nxt_lo == '0);
                        dbz_q    <= is_div && b_zero;
                        done_q   <= 1'b1;
`ifdef ALU_HILO_EN
                        hi_q     <= nxt_hi;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Self-checking bench for alu_multiciclo: directed cases plus randomized ops against an arithmetic model.
module tb_alu_multiciclo;
    localparam int W = 32;
    localparam int S = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_chk  = 0;
    logic [W-1:0] exp_hi = '0;

    alu_multiciclo_if #(.WIDTH(W), .SHW(S)) bus ();
    alu_multiciclo #(.WIDTH(W), .SHW(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    // Reference: spec rules with plain arithmetic; h is the hi word carried across ops.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [S-1:0] s, inout logic [W-1:0] h,
                                  output logic [W-1:0] r, output logic dz);
        logic [2*W-1:0] p;
        dz = 1'b0;
        case (o)
            4'd1:  r = x - y;
            4'd2:  begin p = 64'(x) * 64'(y); r = p[W-1:0]; h = p[2*W-1:W]; end
            4'd3:  if (y == 0) begin r = '1; h = x; dz = 1'b1; end
                   else begin r = x / y; h = x % y; end
            4'd4:  r = x & y;
            4'd5:  r = x | y;
            4'd6:  r = ~(x | y);
            4'd7:  r = y << s;
            4'd8:  r = y >> s;
            4'd9:  r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd10: r = x ^ y;
            default: r = x + y;
        endcase
    endfunction

    // Issues one op, scrambles inputs after acceptance, waits for done.
    // lat = edges from the start edge up to and including the done edge (-1 on timeout).
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [S-1:0] s, output int lat, output int busy_cyc);
        @(negedge clk);
        bus.op = o; bus.a = x; bus.b = y; bus.shamt = s; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.op = 4'($urandom); bus.shamt = S'($urandom);
        lat = 1; busy_cyc = 0;
        while (!bus.done && lat < W + 8) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if ({bus.result, bus.zero, bus.busy, bus.done, bus.div_by_zero} !== {32'h0, 4'b1000})
            $display("FAIL reset_state got res=%h z=%b busy=%b done=%b dbz=%b exp 0/1/0/0/0",
                     bus.result, bus.zero, bus.busy, bus.done, bus.div_by_zero);
        else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== '0) $display("FAIL reset_hi got %h exp 0", bus.hi); else n_pass++;
`endif
    endtask

    task automatic test_add_sub();
        int lat, bc;
        do_op(4'd0, 32'd5, 32'd3, '0, lat, bc);
        n_chk++; if (lat !== 1 || bus.result !== 32'd8)
            $display("FAIL add got lat=%0d res=%h exp lat=1 res=8", lat, bus.result);
        else n_pass++;
        do_op(4'd1, 32'd5, 32'd3, '0, lat, bc);
        n_chk++; if (lat !== 1 || bus.result !== 32'd2 || bus.zero !== 1'b0)
            $display("FAIL sub_b2b got lat=%0d res=%h z=%b exp lat=1 res=2 z=0", lat, bus.result, bus.zero);
        else n_pass++;
        do_op(4'd1, 32'd9, 32'd9, '0, lat, bc);
        n_chk++; if (bus.result !== 32'd0 || bus.zero !== 1'b1)
            $display("FAIL sub_zero got res=%h z=%b exp res=0 z=1", bus.result, bus.zero);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int lat, bc, dones;
        do_op(4'd0, 32'd40, 32'd2, '0, lat, bc);
        @(negedge clk);
        bus.op = 4'd2; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({bus.busy, bus.done, bus.result, bus.zero} !== {2'b00, 32'h0, 1'b1})
            $display("FAIL mid_reset got busy=%b done=%b res=%h z=%b exp 0/0/0/1",
                     bus.busy, bus.done, bus.result, bus.zero);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        exp_hi = '0;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done) dones++; end
        n_chk++; if (dones !== 0 || bus.result !== '0)
            $display("FAIL mid_reset_no_done got dones=%0d res=%h exp 0/0", dones, bus.result);
        else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== '0) $display("FAIL mid_reset_hi got %h exp 0", bus.hi); else n_pass++;
`endif
    endtask

    task automatic test_mul();
        int lat, bc;
        do_op(4'd2, 32'h0001_0000, 32'h0003_0002, '0, lat, bc);
        n_chk++; if (lat !== W + 1 || bc !== W)
            $display("FAIL mul_latency got lat=%0d busy=%0d exp lat=%0d busy=%0d", lat, bc, W + 1, W);
        else n_pass++;
        n_chk++; if (bus.result !== 32'h0002_0000 || bus.div_by_zero !== 1'b0)
            $display("FAIL mul_result got %h dbz=%b exp 00020000 dbz=0", bus.result, bus.div_by_zero);
        else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== 32'h3) $display("FAIL mul_hi got %h exp 3", bus.hi); else n_pass++;
`endif
        exp_hi = 32'h3;
        @(posedge clk); #1;
        n_chk++; if (bus.done !== 1'b0) $display("FAIL mul_done_pulse got done=%b exp 0", bus.done);
        else n_pass++;
    endtask

    task automatic test_div();
        int lat, bc;
        do_op(4'd3, 32'd100, 32'd7, '0, lat, bc);
        n_chk++; if (lat !== W + 1 || bus.result !== 32'd14 || bus.div_by_zero !== 1'b0)
            $display("FAIL div got lat=%0d res=%h dbz=%b exp lat=%0d res=e dbz=0", lat, bus.result, bus.div_by_zero, W + 1);
        else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== 32'd2) $display("FAIL div_rem got %h exp 2", bus.hi); else n_pass++;
`endif
        do_op(4'd3, 32'd50, 32'd0, '0, lat, bc);
        n_chk++; if (lat !== W + 1 || bus.result !== 32'hFFFF_FFFF || bus.div_by_zero !== 1'b1)
            $display("FAIL div_by_zero got lat=%0d res=%h dbz=%b exp lat=%0d res=ffffffff dbz=1", lat, bus.result, bus.div_by_zero, W + 1);
        else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== 32'd50) $display("FAIL div0_rem got %h exp 32", bus.hi); else n_pass++;
`endif
        exp_hi = 32'd50;
        do_op(4'd0, 32'd1, 32'd1, '0, lat, bc);
        n_chk++; if (bus.div_by_zero !== 1'b0 || bus.result !== 32'd2)
            $display("FAIL dbz_clear got dbz=%b res=%h exp 0/2", bus.div_by_zero, bus.result);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int edges, dones;
        @(negedge clk);
        bus.op = 4'd3; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        edges = 1; dones = 0;
        repeat (4) begin @(posedge clk); #1; edges++; end
        @(negedge clk);
        bus.op = 4'd0; bus.a = 32'd1; bus.b = 32'd1; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0; edges++;
        if (bus.done) dones++;
        while (!bus.done && edges < W + 8) begin @(posedge clk); #1; edges++; end
        n_chk++; if (edges !== W + 1 || dones !== 0 || bus.result !== 32'd14)
            $display("FAIL busy_ignore got edges=%0d early_done=%0d res=%h exp %0d/0/e", edges, dones, bus.result, W + 1);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; if (bus.done) dones++; end
        n_chk++; if (dones !== 0 || bus.result !== 32'd14)
            $display("FAIL busy_ignore_extra got dones=%0d res=%h exp 0/e", dones, bus.result);
        else n_pass++;
        exp_hi = 32'd2;
    endtask

    task automatic test_slt_shift_xor();
        int lat, bc;
        do_op(4'd9, 32'hFFFF_FFFF, 32'd1, '0, lat, bc);
        n_chk++; if (bus.result !== 32'd1) $display("FAIL slt got %h exp 1", bus.result); else n_pass++;
        do_op(4'd7, 32'd0, 32'd1, 5'd31, lat, bc);
        n_chk++; if (bus.result !== 32'h8000_0000) $display("FAIL sll got %h exp 80000000", bus.result); else n_pass++;
        do_op(4'd8, 32'd0, 32'h8000_0000, 5'd4, lat, bc);
        n_chk++; if (bus.result !== 32'h0800_0000) $display("FAIL srl got %h exp 08000000", bus.result); else n_pass++;
        do_op(4'd10, 32'h0000_F0F0, 32'h0000_FF00, '0, lat, bc);
        n_chk++; if (bus.result !== 32'h0000_0FF0) $display("FAIL xor got %h exp 00000ff0", bus.result); else n_pass++;
`ifdef ALU_HILO_EN
        n_chk++; if (bus.hi !== exp_hi) $display("FAIL hi_hold got %h exp %h", bus.hi, exp_hi); else n_pass++;
`endif
    endtask

    task automatic test_random();
        int lat, bc, exp_lat;
        logic [3:0]   o;
        logic [W-1:0] x, y, er;
        logic [S-1:0] s;
        logic         edz;
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 5) == 0) y = x;
            if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(8, 28);
            s = S'($urandom);
            model(o, x, y, s, exp_hi, er, edz);
            exp_lat = (o == 4'd2 || o == 4'd3) ? W + 1 : 1;
            do_op(o, x, y, s, lat, bc);
            n_chk++; if (lat !== exp_lat || bus.result !== er || bus.zero !== (er == '0) || bus.div_by_zero !== edz)
                $display("FAIL rand[%0d] op=%0d a=%h b=%h sh=%0d got lat=%0d res=%h z=%b dbz=%b exp lat=%0d res=%h z=%b dbz=%b",
                         i, o, x, y, s, lat, bus.result, bus.zero, bus.div_by_zero, exp_lat, er, (er == '0), edz);
            else n_pass++;
`ifdef ALU_HILO_EN
            n_chk++; if (bus.hi !== exp_hi) $display("FAIL rand_hi[%0d] op=%0d got %h exp %h", i, o, bus.hi, exp_hi);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mid_reset();
        test_mul();
        test_div();
        test_busy_ignore();
        test_slt_shift_xor();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Execution-stage ALU that consumes the 4-bit operation code produced by the ALU control decoder and computes the datapath result.
- Logic, add/sub, shift, XOR and SLT ops complete in 1 cycle. MUL and DIV run iteratively: MUL is shift-add, DIV is unsigned restoring division, each over WIDTH cycles.
- A start/busy/done handshake lets the control unit stall the pipeline while an iterative op is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits; power of two, >= 8.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request to execute op on a/b; sampled only when not busy.
- op  in  4  ALU control code (encodings below).
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt / immediate).
- shamt  in  SHW  shift amount for SLL/SRL.
- result  out  WIDTH  registered result, held until the next done.
- zero  out  1  registered (result == 0), updated with result.
- busy  out  1  high while an iterative op is in progress.
- done  out  1  one-cycle pulse, high in the cycle result becomes valid.
- div_by_zero  out  1  set with done when a DIV had b == 0; otherwise cleared with done.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Op encodings:
  - 0000 ADD; 0001 SUB; 0010 MUL; 0011 DIV; 0100 AND; 0101 OR; 0110 NOR.
  - 0111 SLL (b << shamt); 1000 SRL (b >> shamt, logical).
  - 1001 SLT (signed a < b -> 1, else 0); 1010 XOR.
  - 1011-1111 execute as ADD.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - MUL returns the low WIDTH bits of the product.
  - DIV returns the unsigned quotient.
- Reset: state IDLE; result = 0, zero = 1, busy = 0, done = 0, div_by_zero = 0; iteration counter and internal accumulators cleared. Applies immediately, including mid-iteration; the aborted op produces no done.
- FSM states:
  - IDLE: start=1 with single-cycle op -> result, zero and done=1 registered at the next edge (latency 1); stay IDLE.
  - IDLE: start=1 with MUL/DIV -> latch a and b, counter = 0, go to CALC.
  - CALC: busy=1; one iteration per edge, counter++. On the edge where counter reaches WIDTH: write result, zero and div_by_zero, pulse done, return to IDLE. MUL/DIV latency = WIDTH+1 edges after the start edge.
- Handshake:
  - start while busy is ignored; a, b, op and shamt may change freely during CALC.
  - start is accepted in the same cycle that done is high, so back-to-back ops are allowed.
  - done never stays high for 2 consecutive cycles unless back-to-back single-cycle ops are issued.
- DIV by zero: quotient = all ones; div_by_zero = 1. No early exit; the full WIDTH iterations still run.
- Outputs are stable between done pulses.

Optional Feature:
- Macro: ALU_HILO_EN.
- Defined:
  - Adds output hi [WIDTH-1:0], reset to 0, updated only with done for MUL/DIV.
  - MUL: hi = upper WIDTH bits of the unsigned product.
  - DIV: hi = remainder; remainder = a when b == 0.
  - Single-cycle ops leave hi unchanged.
- Undefined: no hi port; the upper product bits and remainder are discarded.

Test Plan:
- Reset mid-MUL: a=7, b=6, MUL, assert rst 10 cycles after start -> busy=0, done never pulses, result=0, zero=1.
- ADD then SUB back-to-back:
  - a=5, b=3, op=0000 -> done next cycle, result=8.
  - Next cycle op=0001 -> result=2, zero=0.
  - a=b=9, SUB -> result=0, zero=1.
- MUL: a=0x0001_0000, b=0x0003_0002 -> busy for 32 cycles, done at 33rd edge. result=0x0002_0000; with ALU_HILO_EN, hi=0x0000_0003.
- DIV: a=100, b=7 -> result=14, div_by_zero=0 (hi=2 with ALU_HILO_EN). Then a=50, b=0 -> result=0xFFFF_FFFF, div_by_zero=1 (hi=50).
- Start ignored while busy: issue ADD 5 cycles into a DIV -> no extra done; DIV result is unaffected.
- SLT/shift/XOR:
  - a=0xFFFF_FFFF, b=1, SLT -> 1.
  - SLL b=1, shamt=31 -> 0x8000_0000.
  - SRL b=0x8000_0000, shamt=4 -> 0x0800_0000.
  - XOR a=0xF0F0, b=0xFF00 -> 0x0FF0.
